// File: rtl/dma_controller.sv
// Bus-master DMA engine: CPU-programmed 8-register window, copies LEN bytes SRC->DST
// over the shared CPU bus while holding the CPU off with o_halt.
module dma_controller #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rwb,
  input  logic [2:0]  addr,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_halt,
  output logic        o_bus_en,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_rwb,
  output logic [7:0]  o_bus_data,
  input  logic [7:0]  i_bus_data,
  input  logic        i_bus_wait,
  output logic        irqb
);

  localparam int CW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);
  localparam logic [CW-1:0] RW_LAST = CW'(READ_WAIT);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_READ, S_WRITE, S_RELEASE
  } state_t;

  state_t        state;
  logic [15:0]   src, dst, len;
  logic          src_inc, dst_inc, irq_en, done;
  logic [CW-1:0] wait_cnt;

  logic        busy, cpu_acc, status_rd;
  logic [15:0] src_next, dst_next;

  assign busy      = (state != S_IDLE);
  assign cpu_acc   = cs && !o_bus_en;
  assign status_rd = cpu_acc && rwb && (addr == 3'd7);
  assign src_next  = src + {15'd0, src_inc};
  assign dst_next  = dst + {15'd0, dst_inc};

  always_comb begin
    o_data = 8'h00;
    case (addr)
      3'd0: o_data = src[7:0];
      3'd1: o_data = src[15:8];
      3'd2: o_data = dst[7:0];
      3'd3: o_data = dst[15:8];
      3'd4: o_data = len[7:0];
      3'd5: o_data = len[15:8];
      3'd6: o_data = {4'b0000, irq_en, dst_inc, src_inc, 1'b0};
      3'd7: o_data = {6'b000000, done, busy};
      default: o_data = 8'h00;
    endcase
  end

  // o_bus_data doubles as the byte buffer between the READ and WRITE halves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      src_inc    <= 1'b0;
      dst_inc    <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      wait_cnt   <= '0;
      o_halt     <= 1'b0;
      o_bus_en   <= 1'b0;
      o_bus_addr <= '0;
      o_bus_rwb  <= 1'b1;
      o_bus_data <= '0;
      irqb       <= 1'b1;
    end else begin
      // Clear first so a completion in the same cycle wins.
      if (status_rd) begin
        done <= 1'b0;
        irqb <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (cpu_acc && !rwb) begin
            case (addr)
              3'd0: src[7:0]  <= i_data;
              3'd1: src[15:8] <= i_data;
              3'd2: dst[7:0]  <= i_data;
              3'd3: dst[15:8] <= i_data;
              3'd4: len[7:0]  <= i_data;
              3'd5: len[15:8] <= i_data;
              3'd6: begin
                src_inc <= i_data[1];
                dst_inc <= i_data[2];
                irq_en  <= i_data[3];
                if (i_data[0]) begin
                  if (len != 16'd0) begin
                    state  <= S_HALT;
                    o_halt <= 1'b1;
                  end else begin
                    done <= 1'b1;
                    if (i_data[3]) irqb <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        S_HALT: begin
          state      <= S_READ;
          o_bus_en   <= 1'b1;
          o_bus_rwb  <= 1'b1;
          o_bus_addr <= src;
          wait_cnt   <= '0;
        end
        S_READ: begin
          if (!i_bus_wait) begin
            if (wait_cnt == RW_LAST) begin
              state      <= S_WRITE;
              o_bus_data <= i_bus_data;
              o_bus_rwb  <= 1'b0;
              o_bus_addr <= dst;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!i_bus_wait) begin
            len       <= len - 16'd1;
            src       <= src_next;
            dst       <= dst_next;
            o_bus_rwb <= 1'b1;
            if (len == 16'd1) begin
              state    <= S_RELEASE;
              o_bus_en <= 1'b0;
            end else begin
              state      <= S_READ;
              o_bus_addr <= src_next;
              wait_cnt   <= '0;
            end
          end
        end
        S_RELEASE: begin
          state  <= S_IDLE;
          o_halt <= 1'b0;
          done   <= 1'b1;
          if (irq_en) irqb <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: register programming, bus copies against a
// memory model, wait stretching, address wrap, zero-length start and mid-transfer reset.
module tb_dma_controller;
  localparam int RW = 0;

  logic        clk = 1'b0;
  logic        reset, cs, rwb;
  logic [2:0]  addr;
  logic [7:0]  i_data, o_data;
  logic        o_halt, o_bus_en, o_bus_rwb, irqb;
  logic [15:0] o_bus_addr;
  logic [7:0]  o_bus_data, bus_rdata;
  logic        i_bus_wait;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [15:0] rd_starts[$];
  int          rd_at_idx, busy_cycles;
  int          checks = 0;
  int          errors = 0;

  dma_controller #(.READ_WAIT(RW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rwb(rwb), .addr(addr), .i_data(i_data),
    .o_data(o_data), .o_halt(o_halt), .o_bus_en(o_bus_en), .o_bus_addr(o_bus_addr),
    .o_bus_rwb(o_bus_rwb), .o_bus_data(o_bus_data), .i_bus_data(bus_rdata),
    .i_bus_wait(i_bus_wait), .irqb(irqb)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    @(negedge clk); cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; rwb = 1'b1; addr = a; #1 d = o_data;
    @(negedge clk); cs = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    cpu_write(3'd0, s[7:0]);  cpu_write(3'd1, s[15:8]);
    cpu_write(3'd2, d[7:0]);  cpu_write(3'd3, d[15:8]);
    cpu_write(3'd4, n[7:0]);  cpu_write(3'd5, n[15:8]);
  endtask

  // Runs the bus side of a transfer already started; acts as memory and wait source.
  task automatic run_xfer(input int wait_idx, input int wait_n);
    int rd_idx = 0;
    int left = wait_n;
    bit prev_rd = 1'b0;
    bit started = 1'b0;
    bit rd;
    busy_cycles = 0; rd_at_idx = 0;
    rd_starts.delete(); obs_q.delete();
    cs = 1'b0; addr = 3'd7;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (o_data[0]) begin
        started = 1'b1;
        busy_cycles++;
      end else if (started) begin
        break;
      end
      rd = o_bus_en && o_bus_rwb;
      if (rd && !prev_rd) begin
        rd_idx++;
        rd_starts.push_back(o_bus_addr);
      end
      prev_rd = rd;
      if (rd && rd_idx == wait_idx) rd_at_idx++;
      i_bus_wait = rd && (rd_idx == wait_idx) && (left > 0);
      if (i_bus_wait) left--;
      bus_rdata = i_bus_wait ? 8'hEE : mem[o_bus_addr];
      if (o_bus_en && !o_bus_rwb) begin
        obs_q.push_back({o_bus_addr, o_bus_data});
        mem[o_bus_addr] = o_bus_data;
      end
      @(negedge clk);
    end
    i_bus_wait = 1'b0;
    checks++;
    if (!(started && !o_data[0])) begin
      errors++;
      $display("FAIL xfer_timeout started=%0b busy=%0b required completion", started, o_data[0]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = 3'd0; i_data = 8'h00;
    i_bus_wait = 1'b0; bus_rdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({o_halt, o_bus_en, o_bus_rwb, irqb, o_bus_addr, o_bus_data} !== {4'b0011, 16'h0000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs got %b %b %b %b %h %h required 0 0 1 1 0000 00",
               o_halt, o_bus_en, o_bus_rwb, irqb, o_bus_addr, o_bus_data);
    end
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); #1;
      checks++;
      if (o_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d got %h required 00", a, o_data);
      end
    end
  endtask

  task automatic test_basic_copy;
    logic [7:0] d;
    logic [23:0] e, o;
    mem[16'h1000] = 8'hA1; mem[16'h1001] = 8'hB2; mem[16'h1002] = 8'hC3;
    program_regs(16'h1000, 16'h2000, 16'd3);
    exp_q.push_back({16'h2000, 8'hA1});
    exp_q.push_back({16'h2001, 8'hB2});
    exp_q.push_back({16'h2002, 8'hC3});
    cpu_write(3'd6, 8'h07);
    run_xfer(0, 0);
    checks++;
    if (busy_cycles != 2 + 3 * (RW + 2)) begin
      errors++;
      $display("FAIL copy_busy_cycles got %0d required %0d", busy_cycles, 2 + 3 * (RW + 2));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL copy_write missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL copy_write got %h required %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL copy_extra_writes got %0d required 0", obs_q.size()); end
    checks++;
    if (irqb !== 1'b1) begin errors++; $display("FAIL copy_irqb got %b required 1", irqb); end
    cpu_read(3'd7, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL copy_status got %h required 02", d); end
  endtask

  task automatic test_fixed_dst;
    logic [7:0] d, d2;
    logic [23:0] e, o;
    mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22; mem[16'h3002] = 8'h33; mem[16'h3003] = 8'h44;
    program_regs(16'h3000, 16'h7FF0, 16'd4);
    exp_q.push_back({16'h7FF0, 8'h11});
    exp_q.push_back({16'h7FF0, 8'h22});
    exp_q.push_back({16'h7FF0, 8'h33});
    exp_q.push_back({16'h7FF0, 8'h44});
    cpu_write(3'd6, 8'h03);
    run_xfer(0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL fixdst_write missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL fixdst_write got %h required %h", o, e); end
      end
    end
    cpu_read(3'd2, d); cpu_read(3'd3, d2);
    checks++;
    if ({d2, d} !== 16'h7FF0) begin errors++; $display("FAIL fixdst_dst_reg got %h required 7ff0", {d2, d}); end
    cpu_read(3'd4, d); cpu_read(3'd5, d2);
    checks++;
    if ({d2, d} !== 16'h0000) begin errors++; $display("FAIL fixdst_len_reg got %h required 0000", {d2, d}); end
    cpu_read(3'd6, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL fixdst_ctrl_read got %h required 02", d); end
    cpu_read(3'd7, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL fixdst_status got %h required 02", d); end
  endtask

  task automatic test_zero_len;
    logic [7:0] d;
    bit seen_bus = 1'b0;
    cpu_write(3'd6, 8'h09);
    addr = 3'd7; #1;
    checks++;
    if (o_data !== 8'h02 || irqb !== 1'b0) begin
      errors++; $display("FAIL zero_len_done status=%h irqb=%b required 02 0", o_data, irqb);
    end
    for (int i = 0; i < 4; i++) begin
      if (o_bus_en) seen_bus = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_bus) begin errors++; $display("FAIL zero_len_bus got bus_en=1 required 0"); end
    cpu_read(3'd7, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL zero_len_status got %h required 02", d); end
    addr = 3'd7; #1;
    checks++;
    if (irqb !== 1'b1 || o_data !== 8'h00) begin
      errors++; $display("FAIL zero_len_clear irqb=%b status=%h required 1 00", irqb, o_data);
    end
  endtask

  task automatic test_bus_wait;
    logic [7:0] d;
    logic [23:0] e, o;
    mem[16'h4000] = 8'h5A; mem[16'h4001] = 8'h6B; mem[16'h4002] = 8'h7C;
    program_regs(16'h4000, 16'h5000, 16'd3);
    exp_q.push_back({16'h5000, 8'h5A});
    exp_q.push_back({16'h5001, 8'h6B});
    exp_q.push_back({16'h5002, 8'h7C});
    cpu_write(3'd6, 8'h07);
    run_xfer(2, 3);
    checks++;
    if (rd_at_idx != RW + 1 + 3) begin
      errors++; $display("FAIL wait_read_hold got %0d required %0d", rd_at_idx, RW + 4);
    end
    checks++;
    if (rd_starts.size() < 2 || rd_starts[1] !== 16'h4001) begin
      errors++; $display("FAIL wait_read_addr got %0d reads required second at 4001", rd_starts.size());
    end
    checks++;
    if (busy_cycles != 2 + 3 * (RW + 2) + 3) begin
      errors++; $display("FAIL wait_busy_cycles got %0d required %0d", busy_cycles, 5 + 3 * (RW + 2));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wait_write missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wait_write got %h required %h", o, e); end
      end
    end
    cpu_read(3'd7, d);
  endtask

  task automatic test_src_wrap;
    logic [7:0] d, d2;
    logic [23:0] e, o;
    mem[16'hFFFF] = 8'h9A; mem[16'h0000] = 8'h8B;
    program_regs(16'hFFFF, 16'h6000, 16'd2);
    exp_q.push_back({16'h6000, 8'h9A});
    exp_q.push_back({16'h6001, 8'h8B});
    cpu_write(3'd6, 8'h07);
    run_xfer(0, 0);
    checks++;
    if (rd_starts.size() != 2 || rd_starts[0] !== 16'hFFFF || rd_starts[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_read_addrs got %0d reads required ffff then 0000", rd_starts.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wrap_write missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_write got %h required %h", o, e); end
      end
    end
    cpu_read(3'd0, d); cpu_read(3'd1, d2);
    checks++;
    if ({d2, d} !== 16'h0001) begin errors++; $display("FAIL wrap_src_reg got %h required 0001", {d2, d}); end
    cpu_read(3'd7, d);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic [23:0] e, o;
    int n = 0;
    mem[16'h1100] = 8'h0F; mem[16'h1101] = 8'h1E; mem[16'h1102] = 8'h2D;
    program_regs(16'h1100, 16'h2100, 16'd3);
    cpu_write(3'd6, 8'h0F);
    while (n < 50 && !(o_bus_en && !o_bus_rwb)) begin
      bus_rdata = mem[o_bus_addr];
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midreset_no_write got timeout required write cycle"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_halt !== 1'b0 || o_bus_en !== 1'b0 || irqb !== 1'b1) begin
      errors++; $display("FAIL midreset_outputs halt=%b bus_en=%b irqb=%b required 0 0 1", o_halt, o_bus_en, irqb);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); #1;
      checks++;
      if (o_data !== 8'h00) begin errors++; $display("FAIL midreset_reg%0d got %h required 00", a, o_data); end
    end
    program_regs(16'h1100, 16'h2200, 16'd3);
    exp_q.push_back({16'h2200, 8'h0F});
    exp_q.push_back({16'h2201, 8'h1E});
    exp_q.push_back({16'h2202, 8'h2D});
    cpu_write(3'd6, 8'h0F);
    run_xfer(0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL restart_write missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL restart_write got %h required %h", o, e); end
      end
    end
    checks++;
    if (irqb !== 1'b0) begin errors++; $display("FAIL restart_irqb got %b required 0", irqb); end
    cpu_read(3'd7, d);
    checks++;
    if (d !== 8'h02 || irqb !== 1'b1) begin
      errors++; $display("FAIL restart_status got %h irqb=%b required 02 1", d, irqb);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_fixed_dst();
    test_zero_len();
    test_bus_wait();
    test_src_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
